dtc_marker_decoder: RTL

Receive-side decoder for the DTC marker protocol on the transceiver link. Sits after the RX 8b/10b lane in the XCVR_CLK domain, monitors every 16-bit word and its K-flags, recognises clock, event, loopback, diagnostic, timeout and retransmission markers, and checks their double-word and sequence framing. Each recognised marker produces a single-cycle pulse, and each protocol violation produces a classified error pulse. Separate counters track markers and errors for slow-control readout.

---
 rtl/dtc_marker_pkg.sv | 59 +++++
 rtl/dtc_event_counter.sv | 29 ++
 rtl/dtc_marker_decoder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/dtc_marker_pkg.sv
// Shared definitions for the DTC marker decoder: K-flag codes, word
// constants, error classes and the framing FSM state type.
package dtc_marker_pkg;

   // K-flag codes as delivered by the RX 8b/10b lane
   localparam logic [1:0] K_COMMA = 2'b11;
   localparam logic [1:0] K_CMD   = 2'b10;
   localparam logic [1:0] K_DATA  = 2'b00;

   // Idle comma word and the common command prefix
   localparam logic [15:0] W_COMMA    = 16'hBC3C;
   localparam logic [7:0]  CMD_PREFIX = 8'h1C;

   // Low bytes of first words
   localparam logic [7:0] LB_DCS      = 8'h00;
   localparam logic [7:0] LB_EVENT    = 8'h10;
   localparam logic [7:0] LB_CLOCK    = 8'h11;
   localparam logic [7:0] LB_LOOPBACK = 8'h12;
   localparam logic [7:0] LB_DIAG     = 8'h13;
   localparam logic [7:0] LB_TIMEOUT  = 8'h14;
   localparam logic [7:0] LB_RETRANS  = 8'h15;

   // Low bytes of complement words
   localparam logic [7:0] LB_RETRANS_COMP  = 8'hEA;
   localparam logic [7:0] LB_LOOPBACK_COMP = 8'hED;
   localparam logic [7:0] LB_CLOCK_COMP    = 8'hEE;
   localparam logic [7:0] LB_EVENT_COMP    = 8'hEF;

   typedef enum logic [2:0] {
      ERR_NONE         = 3'd0,
      ERR_MISSING_COMP = 3'd1,
      ERR_WRONG_COMP   = 3'd2,
      ERR_REPEAT_FIRST = 3'd3,
      ERR_ORPHAN_COMP  = 3'd4,
      ERR_BAD_SEQ      = 3'd5,
      ERR_MISSING_SEQ  = 3'd6,
      ERR_ILLEGAL_CMD  = 3'd7
   } err_code_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_CLK_N,
      ST_WAIT_EVT_N,
      ST_WAIT_RTX_N,
      ST_WAIT_RTX_SEQ
   } state_t;

   // A command word is legal only when its high byte carries the prefix
   function automatic logic is_legal_cmd(input logic [15:0] word);
      return word[15:8] == CMD_PREFIX;
   endfunction

   // Retransmission sequence words repeat one nibble four times
   function automatic logic nibbles_equal(input logic [15:0] word);
      return (word[15:12] == word[3:0]) && (word[11:8] == word[3:0]) &&
             (word[7:4] == word[3:0]);
   endfunction

endpackage

// File: rtl/dtc_event_counter.sv
// Wrapping event counter with synchronous clear; a clear coinciding with
// an increment loads 1 so that event is not lost.
module dtc_event_counter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_inc,
   input  logic                 i_clr,
   output logic [CNT_WIDTH-1:0] o_count
);

   logic [CNT_WIDTH-1:0] r_count;

   // Count events, clear on request, wrap naturally on overflow
   always_ff @(posedge i_clk or posedge i_rst) begin
      // NOTE: sequential state is always updated with non-blocking assignments
      if (i_rst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= {{(CNT_WIDTH-1){1'b0}}, i_inc};
      end else if (i_inc) begin
         r_count <= r_count + CNT_WIDTH'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/dtc_marker_decoder.sv
// Receive-side DTC marker decoder: frames double-word and sequence markers,
// emits one-cycle marker/error pulses and keeps marker/error counters.
module dtc_marker_decoder
   import dtc_marker_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 XCVR_CLK,
   input  logic                 XCVR_RESET,
   input  logic                 RX_LOCK,
   input  logic [15:0]          DATA_FROM_RX,
   input  logic [1:0]           KCHAR_FROM_RX,
   input  logic                 CNT_CLEAR,
   output logic                 CLOCK_MARKER,
   output logic                 EVENT_MARKER,
   output logic                 LOOPBACK_MARKER,
   output logic                 DIAG_MARKER,
   output logic                 TIMEOUT_MARKER,
   output logic                 RETRANS_REQ,
   output logic [3:0]           RETRANS_SEQ,
   output logic                 DCS_REQ_START,
   output logic                 UNDEF_CMD,
   output logic                 ERR_VALID,
   output logic [2:0]           ERR_CODE,
   output logic [CNT_WIDTH-1:0] MARKER_CNT,
   output logic [CNT_WIDTH-1:0] ERROR_CNT
);

   state_t    r_state;
   logic      r_clock, r_event, r_loopback, r_diag, r_timeout, r_retrans;
   logic      r_dcs, r_undef, r_err_valid;
   logic [3:0] r_retrans_seq;
   err_code_t r_err_code;

   logic        w_is_cmd;
   logic        w_legal;
   logic [15:0] w_expected_comp;
   logic [15:0] w_own_first;
   logic        w_marker_inc;
   logic        w_err_inc;
   logic        w_cnt_clr;

   assign w_is_cmd = (KCHAR_FROM_RX == K_CMD);
   assign w_legal  = is_legal_cmd(DATA_FROM_RX);

   // Complement and opener that belong to the pending double-word sequence
   assign w_expected_comp = (r_state == ST_WAIT_CLK_N) ? {CMD_PREFIX, LB_CLOCK_COMP} :
                            (r_state == ST_WAIT_EVT_N) ? {CMD_PREFIX, LB_EVENT_COMP} :
                                                         {CMD_PREFIX, LB_RETRANS_COMP};
   assign w_own_first     = (r_state == ST_WAIT_CLK_N) ? {CMD_PREFIX, LB_CLOCK} :
                            (r_state == ST_WAIT_EVT_N) ? {CMD_PREFIX, LB_EVENT} :
                                                         {CMD_PREFIX, LB_RETRANS};

   // Framing FSM with registered pulse, sequence and error outputs
   always_ff @(posedge XCVR_CLK or posedge XCVR_RESET) begin
      if (XCVR_RESET) begin
         r_state       <= ST_IDLE;
         r_clock       <= 1'b0;
         r_event       <= 1'b0;
         r_loopback    <= 1'b0;
         r_diag        <= 1'b0;
         r_timeout     <= 1'b0;
         r_retrans     <= 1'b0;
         r_dcs         <= 1'b0;
         r_undef       <= 1'b0;
         r_err_valid   <= 1'b0;
         r_retrans_seq <= '0;
         r_err_code    <= ERR_NONE;
      end else begin
         // NOTE: pulses default low each cycle and are raised only by the branch that fires them
         r_clock     <= 1'b0;
         r_event     <= 1'b0;
         r_loopback  <= 1'b0;
         r_diag      <= 1'b0;
         r_timeout   <= 1'b0;
         r_retrans   <= 1'b0;
         r_dcs       <= 1'b0;
         r_undef     <= 1'b0;
         r_err_valid <= 1'b0;
         if (!RX_LOCK) begin
            r_state <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_is_cmd) begin
                     if (!w_legal) begin
                        r_err_valid <= 1'b1;
                        r_err_code  <= ERR_ILLEGAL_CMD;
                     end else begin
                        case (DATA_FROM_RX[7:0])
                           LB_CLOCK:    r_state    <= ST_WAIT_CLK_N;
                           LB_EVENT:    r_state    <= ST_WAIT_EVT_N;
                           LB_RETRANS:  r_state    <= ST_WAIT_RTX_N;
                           LB_LOOPBACK: r_loopback <= 1'b1;
                           LB_DIAG:     r_diag     <= 1'b1;
                           LB_TIMEOUT:  r_timeout  <= 1'b1;
                           LB_DCS:      r_dcs      <= 1'b1;
                           LB_CLOCK_COMP, LB_EVENT_COMP,
                           LB_RETRANS_COMP, LB_LOOPBACK_COMP: begin
                              r_err_valid <= 1'b1;
                              r_err_code  <= ERR_ORPHAN_COMP;
                           end
                           default:     r_undef    <= 1'b1;
                        endcase
                     end
                  end
               end
               ST_WAIT_CLK_N, ST_WAIT_EVT_N, ST_WAIT_RTX_N: begin
                  // The second word is always consumed here, never re-parsed
                  r_state <= ST_IDLE;
                  if (!w_is_cmd) begin
                     r_err_valid <= 1'b1;
                     r_err_code  <= ERR_MISSING_COMP;
                  end else if (!w_legal) begin
                     r_err_valid <= 1'b1;
                     r_err_code  <= ERR_ILLEGAL_CMD;
                  end else if (DATA_FROM_RX == w_expected_comp) begin
                     if (r_state == ST_WAIT_CLK_N)      r_clock <= 1'b1;
                     else if (r_state == ST_WAIT_EVT_N) r_event <= 1'b1;
                     else                               r_state <= ST_WAIT_RTX_SEQ;
                  end else if (DATA_FROM_RX == w_own_first) begin
                     r_err_valid <= 1'b1;
                     r_err_code  <= ERR_REPEAT_FIRST;
                  end else begin
                     r_err_valid <= 1'b1;
                     r_err_code  <= ERR_WRONG_COMP;
                  end
               end
               ST_WAIT_RTX_SEQ: begin
                  r_state <= ST_IDLE;
                  if (KCHAR_FROM_RX != K_DATA) begin
                     r_err_valid <= 1'b1;
                     r_err_code  <= ERR_MISSING_SEQ;
                  end else if (nibbles_equal(DATA_FROM_RX)) begin
                     r_retrans     <= 1'b1;
                     r_retrans_seq <= DATA_FROM_RX[3:0];
                  end else begin
                     r_err_valid <= 1'b1;
                     r_err_code  <= ERR_BAD_SEQ;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   // Counters advance from the visible pulses and freeze while unlocked
   assign w_marker_inc = RX_LOCK & (r_clock | r_event | r_loopback | r_diag |
                                    r_timeout | r_retrans);
   assign w_err_inc    = RX_LOCK & r_err_valid;
   assign w_cnt_clr    = RX_LOCK & CNT_CLEAR;

   dtc_event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_marker_cnt (
      .i_clk   (XCVR_CLK),
      .i_rst   (XCVR_RESET),
      .i_inc   (w_marker_inc),
      .i_clr   (w_cnt_clr),
      .o_count (MARKER_CNT)
   );

   dtc_event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_error_cnt (
      .i_clk   (XCVR_CLK),
      .i_rst   (XCVR_RESET),
      .i_inc   (w_err_inc),
      .i_clr   (w_cnt_clr),
      .o_count (ERROR_CNT)
   );

   assign CLOCK_MARKER    = r_clock;
   assign EVENT_MARKER    = r_event;
   assign LOOPBACK_MARKER = r_loopback;
   assign DIAG_MARKER     = r_diag;
   assign TIMEOUT_MARKER  = r_timeout;
   assign RETRANS_REQ     = r_retrans;
   assign RETRANS_SEQ     = r_retrans_seq;
   assign DCS_REQ_START   = r_dcs;
   assign UNDEF_CMD       = r_undef;
   assign ERR_VALID       = r_err_valid;
   assign ERR_CODE        = r_err_code;

endmodule
